// File: rtl/seg_marquee_pkg.sv
// Shared constants and state encoding for the scrolling 7-segment marquee.
// No logic here; imported by the marquee top and its interface users.
package mp_pkg;

    localparam logic [7:0] ASCII_BLANK = 8'h00;
    localparam logic [7:0] ASCII_H     = 8'h68;

    typedef enum logic {
        IDLE   = 1'b0,
        SCROLL = 1'b1
    } marq_state_t;

endpackage

// File: rtl/seg_marquee_if.sv
// Host-side control/load bus plus the six digit codes of the marquee.
// wr_ready is the only flow-control signal; everything else is level or pulse.
interface seg_marquee_if #(
    parameter int MSG_DEPTH = 16
);
    localparam int LW = $clog2(MSG_DEPTH + 1);

    logic          clear;
    logic          wr_en;
    logic [7:0]    wr_char;
    logic          wr_ready;
    logic          start;
    logic          pause;
    logic          loop;
    logic          busy;
    logic [LW-1:0] msg_len;
    logic [7:0]    ascii5;
    logic [7:0]    ascii4;
    logic [7:0]    ascii3;
    logic [7:0]    ascii2;
    logic [7:0]    ascii1;
    logic [7:0]    ascii0;

    modport master (
        output clear, wr_en, wr_char, start, pause, loop,
        input  wr_ready, busy, msg_len,
        input  ascii5, ascii4, ascii3, ascii2, ascii1, ascii0
    );

    modport slave (
        input  clear, wr_en, wr_char, start, pause, loop,
        output wr_ready, busy, msg_len,
        output ascii5, ascii4, ascii3, ascii2, ascii1, ascii0
    );

endinterface

// File: rtl/seg_marquee_tick_gen.sv
// Two-stage prescaler: TICK_MAX clocks per tick, STEP_TICKS ticks per step.
// step is a combinational 1-cycle pulse; counters freeze while en is low.
module tick_gen #(
    parameter int TICK_MAX   = 25000,
    parameter int STEP_TICKS = 250
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic sync_clr,
    output logic step
);
    localparam int TW = (TICK_MAX > 1)   ? $clog2(TICK_MAX)   : 1;
    localparam int SW = (STEP_TICKS > 1) ? $clog2(STEP_TICKS) : 1;

    logic [TW-1:0] tick_cnt;
    logic [SW-1:0] step_cnt;
    logic          tick_wrap;
    logic          step_wrap;

    assign tick_wrap = (tick_cnt == TW'(TICK_MAX - 1));
    assign step_wrap = (step_cnt == SW'(STEP_TICKS - 1));
    assign step      = en && tick_wrap && step_wrap;

    always_ff @(posedge clk) begin
        if (reset || sync_clr) begin
            tick_cnt <= '0;
            step_cnt <= '0;
        end else if (en) begin
            if (tick_wrap) begin
                tick_cnt <= '0;
                step_cnt <= step_wrap ? '0 : step_cnt + 1'b1;
            end else begin
                tick_cnt <= tick_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/seg_marquee.sv
// Scrolls a host-loaded message right-to-left across six ASCII digit codes.
// Digits are registered one cycle behind pos; writes are refused (wr_ready=0) while scrolling or full.
module seg_marquee
    import mp_pkg::*;
#(
    parameter int MSG_DEPTH  = 16,
    parameter int TICK_MAX   = 25000,
    parameter int STEP_TICKS = 250,
    parameter int DIGITS     = 6
) (
    input  logic          clk,
    input  logic          reset,
    seg_marquee_if.slave  bus
);
    localparam int LW = $clog2(MSG_DEPTH + 1);
    localparam int PW = $clog2(MSG_DEPTH + DIGITS);
    localparam int IW = $clog2(2 * (MSG_DEPTH + DIGITS));
    localparam int BW = (MSG_DEPTH > 1) ? $clog2(MSG_DEPTH) : 1;

    marq_state_t   state;
    logic          loop_q;
    logic [LW-1:0] msg_len_q;
    logic [PW-1:0] pos;
    logic [7:0]    msg_buf   [MSG_DEPTH];
    logic [7:0]    digit_nxt [DIGITS];
    logic [7:0]    digit_q   [DIGITS];

    logic          scrolling;
    logic          start_ok;
    logic          wr_ok;
    logic          step;
    logic          last_pos;
    logic [IW-1:0] vlen;

    assign scrolling = (state == SCROLL);
    assign start_ok  = bus.start && (msg_len_q != '0);
    assign wr_ok     = bus.wr_en && bus.wr_ready;
    assign vlen      = IW'(msg_len_q) + IW'(DIGITS);
    assign last_pos  = (IW'(pos) == vlen - 1'b1);

    tick_gen #(
        .TICK_MAX   (TICK_MAX),
        .STEP_TICKS (STEP_TICKS)
    ) u_tick_gen (
        .clk      (clk),
        .reset    (reset),
        .en       (scrolling && !bus.pause),
        .sync_clr (bus.clear || start_ok),
        .step     (step)
    );

    // Control priority: reset > clear > start > step/write.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            loop_q    <= 1'b0;
            msg_len_q <= '0;
            pos       <= '0;
        end else if (bus.clear) begin
            state     <= IDLE;
            msg_len_q <= '0;
            pos       <= '0;
        end else if (start_ok) begin
            state  <= SCROLL;
            pos    <= '0;
            loop_q <= bus.loop;
        end else if (scrolling) begin
            if (step) begin
                if (last_pos) begin
                    pos <= '0;
                    if (!loop_q) begin
                        state <= IDLE;
                    end
                end else begin
                    pos <= pos + 1'b1;
                end
            end
        end else if (wr_ok) begin
            msg_len_q <= msg_len_q + 1'b1;
        end
    end

    // Buffer contents survive reset; msg_len alone defines what is valid.
    always_ff @(posedge clk) begin
        if (!reset && !bus.clear && !start_ok && wr_ok) begin
            msg_buf[msg_len_q[BW-1:0]] <= bus.wr_char;
        end
    end

    // Virtual string: DIGITS blanks followed by the message, indexed mod V.
    for (genvar k = 0; k < DIGITS; k++) begin : g_digit
        logic [IW-1:0] raw_idx;
        logic [IW-1:0] wrap_idx;
        logic [BW-1:0] buf_idx;

        always_comb begin
            raw_idx      = IW'(pos) + IW'(DIGITS - 1 - k);
            wrap_idx     = (raw_idx >= vlen) ? raw_idx - vlen : raw_idx;
            buf_idx      = BW'(wrap_idx - IW'(DIGITS));
            digit_nxt[k] = (wrap_idx < IW'(DIGITS)) ? ASCII_BLANK : msg_buf[buf_idx];
        end
    end

    always_ff @(posedge clk) begin
        for (int k = 0; k < DIGITS; k++) begin
            if (reset) begin
                digit_q[k] <= ASCII_BLANK;
            end else begin
                digit_q[k] <= scrolling ? digit_nxt[k] : ASCII_BLANK;
            end
        end
    end

    assign bus.busy     = scrolling;
    assign bus.wr_ready = !scrolling && (msg_len_q < LW'(MSG_DEPTH));
    assign bus.msg_len  = msg_len_q;
    assign bus.ascii0   = digit_q[0];
    assign bus.ascii1   = digit_q[1];
    assign bus.ascii2   = digit_q[2];
    assign bus.ascii3   = digit_q[3];
    assign bus.ascii4   = digit_q[4];
    assign bus.ascii5   = digit_q[5];

endmodule
